// File: rtl/HighLevelControl.sv
// Shared control types for the memory stage.
//   memOperation : memory operation class presented by the execute stage
//   mauState     : memory access unit FSM state
//   is_load / is_store : helpers classifying a memOperation
package HighLevelControl;

  typedef enum logic [3:0] {
    MEM_NONE,
    LB,
    LH,
    LW,
    LBU,
    LHU,
    SB,
    SH,
    SW
  } memOperation;

  typedef enum logic {
    MAU_IDLE,
    MAU_BUSY
  } mauState;

  function automatic logic is_load(input memOperation op);
    return op inside {LB, LH, LW, LBU, LHU};
  endfunction

  function automatic logic is_store(input memOperation op);
    return op inside {SB, SH, SW};
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load lane selection and extension.
// Ports:
//   rdata  in  32  raw word from the data-memory bus
//   op     in      memory operation of the completing transfer
//   off    in  2   byte offset within the word (addr[1:0])
//   result out 32  lane-selected, sign/zero-extended load value
// Halfwords only look at off[1]; words ignore the offset entirely, so a
// misaligned access (when not trapped) reads the enclosing aligned unit.
module load_extend
  import HighLevelControl::*;
(
  input  logic [31:0] rdata,
  input  memOperation op,
  input  logic [1:0]  off,
  output logic [31:0] result
);

  logic [31:0] byte_shifted;
  logic [31:0] half_shifted;

  always_comb begin
    byte_shifted = rdata >> {off, 3'b000};
    half_shifted = rdata >> {off[1], 4'b0000};
    result       = rdata;
    case (op)
      LB:      result = {{24{byte_shifted[7]}}, byte_shifted[7:0]};
      LBU:     result = {24'h0, byte_shifted[7:0]};
      LH:      result = {{16{half_shifted[15]}}, half_shifted[15:0]};
      LHU:     result = {16'h0, half_shifted[15:0]};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access_unit.sv
// Memory-stage load/store unit. Accepts a memory op from the execute stage,
// runs a single req/ready transfer on the data bus, stalls the pipeline while
// it is outstanding and returns an extended load result.
// Optional feature macro: MISALIGN_TRAP_EN (reject misaligned halfword/word ops).
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   MemOpValid      execute stage presents a memory op
//   MemOp           operation (memOperation)
//   ALUResult       effective byte address
//   StoreData       store data (rs2)
//   StallM          hold upstream stages (combinational)
//   LoadResult      extended load data (registered)
//   LoadValid       1-cycle pulse, LoadResult valid
//   BusError        1-cycle pulse, transfer aborted by timeout
//   MisalignFault   1-cycle pulse, misaligned op rejected
//   MemReq/MemWe/MemAddr/MemWData/MemByteEn  bus request side
//   MemReady/MemRData                        bus response side
module memory_access_unit
  import HighLevelControl::*;
#(
  parameter int BIT_COUNT = 32,
  parameter int MAX_WAIT  = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 MemOpValid,
  input  memOperation          MemOp,
  input  logic [BIT_COUNT-1:0] ALUResult,
  input  logic [BIT_COUNT-1:0] StoreData,
  output logic                 StallM,
  output logic [BIT_COUNT-1:0] LoadResult,
  output logic                 LoadValid,
  output logic                 BusError,
  output logic                 MisalignFault,
  output logic                 MemReq,
  output logic                 MemWe,
  output logic [BIT_COUNT-1:0] MemAddr,
  output logic [BIT_COUNT-1:0] MemWData,
  output logic [3:0]           MemByteEn,
  input  logic                 MemReady,
  input  logic [BIT_COUNT-1:0] MemRData
);

  // The wait counter only has to reach MAX_WAIT-1: the abort fires in the
  // cycle where that count is seen together with !MemReady.
  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [CW-1:0] LAST_WAIT = CW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);
  localparam bit TIMEOUT_EN = (MAX_WAIT > 0);

  mauState                state_reg, state_next;
  memOperation            op_reg;
  logic [BIT_COUNT-1:0]   addr_reg;
  logic [BIT_COUNT-1:0]   wdata_reg, wdata_next;
  logic [3:0]             be_reg, be_next;
  logic                   we_reg;
  logic [CW-1:0]          wait_cnt_reg;
  logic [BIT_COUNT-1:0]   load_result_reg;
  logic                   load_valid_reg;
  logic                   bus_error_reg;
  logic                   misalign_reg;

  logic                   accept;
  logic                   complete;
  logic                   abort;
  logic                   misalign_hit;
  logic                   is_misaligned;
  logic                   stall;
  logic [BIT_COUNT-1:0]   ext_result;

  // Lane steering for the op being presented; latched on acceptance so the
  // bus sees stable values for the whole transfer.
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = StoreData;
    case (MemOp)
      LB, LBU, SB: begin
        be_next    = 4'b0001 << ALUResult[1:0];
        wdata_next = {4{StoreData[7:0]}};
      end
      LH, LHU, SH: begin
        be_next    = 4'b0011 << {ALUResult[1], 1'b0};
        wdata_next = {2{StoreData[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = StoreData;
      end
    endcase
  end

  always_comb begin
    is_misaligned = 1'b0;
`ifdef MISALIGN_TRAP_EN
    case (MemOp)
      LH, LHU, SH: is_misaligned = ALUResult[0];
      LW, SW:      is_misaligned = |ALUResult[1:0];
      default:     is_misaligned = 1'b0;
    endcase
`endif
  end

  always_comb begin
    state_next   = state_reg;
    stall        = 1'b0;
    accept       = 1'b0;
    complete     = 1'b0;
    abort        = 1'b0;
    misalign_hit = 1'b0;
    case (state_reg)
      MAU_IDLE: begin
        if (MemOpValid && (MemOp != MEM_NONE)) begin
          if (is_misaligned) begin
            misalign_hit = 1'b1;
          end else begin
            accept     = 1'b1;
            stall      = 1'b1;
            state_next = MAU_BUSY;
          end
        end
      end
      MAU_BUSY: begin
        if (MemReady) begin
          complete   = 1'b1;
          state_next = MAU_IDLE;
        end else if (TIMEOUT_EN && (wait_cnt_reg == LAST_WAIT)) begin
          abort      = 1'b1;
          state_next = MAU_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_next = MAU_IDLE;
    endcase
  end

  load_extend u_load_extend (
    .rdata  (MemRData),
    .op     (op_reg),
    .off    (addr_reg[1:0]),
    .result (ext_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= MAU_IDLE;
      op_reg          <= MEM_NONE;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      be_reg          <= 4'b0000;
      we_reg          <= 1'b0;
      wait_cnt_reg    <= '0;
      load_result_reg <= '0;
      load_valid_reg  <= 1'b0;
      bus_error_reg   <= 1'b0;
      misalign_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      load_valid_reg <= complete && is_load(op_reg);
      bus_error_reg  <= abort;
      misalign_reg   <= misalign_hit;
      if (accept) begin
        op_reg       <= MemOp;
        addr_reg     <= ALUResult;
        wdata_reg    <= wdata_next;
        be_reg       <= be_next;
        we_reg       <= is_store(MemOp);
        wait_cnt_reg <= '0;
      end else if ((state_reg == MAU_BUSY) && !MemReady) begin
        wait_cnt_reg <= wait_cnt_reg + CW'(1);
      end
      if (complete && is_load(op_reg)) begin
        load_result_reg <= ext_result;
      end
    end
  end

  // Reset overrides the stall so upstream stages are released immediately.
  assign StallM        = stall && !reset;
  assign MemReq        = (state_reg == MAU_BUSY);
  assign MemWe         = we_reg;
  assign MemAddr       = {addr_reg[BIT_COUNT-1:2], 2'b00};
  assign MemWData      = wdata_reg;
  assign MemByteEn     = be_reg;
  assign LoadResult    = load_result_reg;
  assign LoadValid     = load_valid_reg;
  assign BusError      = bus_error_reg;
`ifdef MISALIGN_TRAP_EN
  assign MisalignFault = misalign_reg;
`else
  assign MisalignFault = 1'b0;
`endif

endmodule

// File: tb/tb_memory_access_unit.sv
module tb_memory_access_unit;
  import HighLevelControl::*;

  logic        clk;
  logic        reset;
  logic        MemOpValid;
  memOperation MemOp;
  logic [31:0] ALUResult;
  logic [31:0] StoreData;
  logic        StallM;
  logic [31:0] LoadResult;
  logic        LoadValid;
  logic        BusError;
  logic        MisalignFault;
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic [3:0]  MemByteEn;
  logic        MemReady;
  logic [31:0] MemRData;

  int vectors = 0;
  int miscompares = 0;

  memory_access_unit #(.BIT_COUNT(32), .MAX_WAIT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .MemOpValid    (MemOpValid),
    .MemOp         (MemOp),
    .ALUResult     (ALUResult),
    .StoreData     (StoreData),
    .StallM        (StallM),
    .LoadResult    (LoadResult),
    .LoadValid     (LoadValid),
    .BusError      (BusError),
    .MisalignFault (MisalignFault),
    .MemReq        (MemReq),
    .MemWe         (MemWe),
    .MemAddr       (MemAddr),
    .MemWData      (MemWData),
    .MemByteEn     (MemByteEn),
    .MemReady      (MemReady),
    .MemRData      (MemRData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one op and observes the transfer. Starts and ends 1 time unit after
  // a rising edge. ready_after = number of BUSY cycles with MemReady low.
  task automatic run_op(input memOperation op, input logic [31:0] addr,
                        input logic [31:0] sd, input logic [31:0] rdata,
                        input int ready_after,
                        output int stall_n, output int req_n,
                        output logic [31:0] addr_s, output logic [31:0] wdata_s,
                        output logic [3:0] be_s, output logic we_s,
                        output logic mis_s, output logic lv_s, output logic [31:0] lr_s,
                        output logic berr_s, output logic lv_after, output logic berr_after);
    int cyc;
    stall_n = 0; req_n = 0; cyc = 0;
    addr_s = '0; wdata_s = '0; be_s = '0; we_s = 1'b0;
    MemOpValid = 1'b1; MemOp = op; ALUResult = addr; StoreData = sd;
    MemRData = rdata; MemReady = 1'b0;
    #1;
    if (StallM) stall_n++;
    @(posedge clk); #1;
    MemOpValid = 1'b0; MemOp = MEM_NONE;
    mis_s = MisalignFault;
    while (MemReq && cyc < 20) begin
      addr_s = MemAddr; wdata_s = MemWData; be_s = MemByteEn; we_s = MemWe;
      MemReady = (cyc >= ready_after);
      #1;
      if (StallM) stall_n++;
      req_n++;
      @(posedge clk); #1;
      MemReady = 1'b0;
      cyc++;
    end
    lv_s = LoadValid; lr_s = LoadResult; berr_s = BusError;
    @(posedge clk); #1;
    lv_after = LoadValid; berr_after = BusError;
    $display("txn op=%s addr=%h sd=%h rdata=%h req=%0d stall=%0d be=%b wdata=%h lv=%b res=%h berr=%b mis=%b",
             op.name(), addr, sd, rdata, req_n, stall_n, be_s, wdata_s, lv_s, lr_s, berr_s, mis_s);
  endtask

  task automatic test_reset();
    reset = 1'b1; MemOpValid = 1'b1; MemOp = LW; ALUResult = 32'h100;
    StoreData = 32'h0; MemReady = 1'b0; MemRData = 32'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    vectors++; if (StallM !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b expected 0", StallM); end
    vectors++; if (MemReq !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b expected 0", MemReq); end
    vectors++; if ({LoadValid, BusError, MisalignFault, MemWe, MemByteEn} !== 8'h00) begin
      miscompares++; $display("FAIL reset_flags: got %b expected 00000000", {LoadValid, BusError, MisalignFault, MemWe, MemByteEn}); end
    vectors++; if ({LoadResult, MemAddr, MemWData} !== 96'h0) begin
      miscompares++; $display("FAIL reset_data: got %h expected 0", {LoadResult, MemAddr, MemWData}); end
    MemOpValid = 1'b0; MemOp = MEM_NONE; reset = 1'b0;
    @(posedge clk); #1;
    $display("txn reset released");
  endtask

  task automatic test_store_word();
    int st, rq; logic [31:0] a, w, lr; logic [3:0] be; logic we, mis, lv, be_e, lv2, be2;
    run_op(SW, 32'h100, 32'hDEADBEEF, 32'h0, 0, st, rq, a, w, be, we, mis, lv, lr, be_e, lv2, be2);
    vectors++; if (rq !== 1) begin miscompares++; $display("FAIL sw_req_cycles: got %0d expected 1", rq); end
    vectors++; if (st !== 1) begin miscompares++; $display("FAIL sw_stall_cycles: got %0d expected 1", st); end
    vectors++; if (a !== 32'h100) begin miscompares++; $display("FAIL sw_addr: got %h expected 00000100", a); end
    vectors++; if (be !== 4'b1111) begin miscompares++; $display("FAIL sw_be: got %b expected 1111", be); end
    vectors++; if (w !== 32'hDEADBEEF) begin miscompares++; $display("FAIL sw_wdata: got %h expected deadbeef", w); end
    vectors++; if (we !== 1'b1) begin miscompares++; $display("FAIL sw_we: got %b expected 1", we); end
    vectors++; if (lv !== 1'b0) begin miscompares++; $display("FAIL sw_loadvalid: got %b expected 0", lv); end
  endtask

  task automatic test_loads();
    int st, rq; logic [31:0] a, w, lr; logic [3:0] be; logic we, mis, lv, be_e, lv2, be2;
    run_op(LB, 32'h103, 32'h0, 32'h80FF1234, 3, st, rq, a, w, be, we, mis, lv, lr, be_e, lv2, be2);
    vectors++; if (st !== 4) begin miscompares++; $display("FAIL lb_stall_cycles: got %0d expected 4", st); end
    vectors++; if (rq !== 4) begin miscompares++; $display("FAIL lb_req_cycles: got %0d expected 4", rq); end
    vectors++; if (be !== 4'b1000) begin miscompares++; $display("FAIL lb_be: got %b expected 1000", be); end
    vectors++; if (a !== 32'h100) begin miscompares++; $display("FAIL lb_addr: got %h expected 00000100", a); end
    vectors++; if (we !== 1'b0) begin miscompares++; $display("FAIL lb_we: got %b expected 0", we); end
    vectors++; if (lv !== 1'b1) begin miscompares++; $display("FAIL lb_loadvalid: got %b expected 1", lv); end
    vectors++; if (lr !== 32'hFFFFFF80) begin miscompares++; $display("FAIL lb_result: got %h expected ffffff80", lr); end
    vectors++; if (lv2 !== 1'b0) begin miscompares++; $display("FAIL lb_loadvalid_pulse: got %b expected 0", lv2); end
    run_op(LBU, 32'h103, 32'h0, 32'h80FF1234, 3, st, rq, a, w, be, we, mis, lv, lr, be_e, lv2, be2);
    vectors++; if (lr !== 32'h00000080) begin miscompares++; $display("FAIL lbu_result: got %h expected 00000080", lr); end
    vectors++; if (lv !== 1'b1) begin miscompares++; $display("FAIL lbu_loadvalid: got %b expected 1", lv); end
    run_op(LH, 32'h102, 32'h0, 32'h80FF1234, 1, st, rq, a, w, be, we, mis, lv, lr, be_e, lv2, be2);
    vectors++; if (lr !== 32'hFFFF80FF) begin miscompares++; $display("FAIL lh_result: got %h expected ffff80ff", lr); end
    vectors++; if (be !== 4'b1100) begin miscompares++; $display("FAIL lh_be: got %b expected 1100", be); end
    run_op(LHU, 32'h100, 32'h0, 32'h80FF9234, 0, st, rq, a, w, be, we, mis, lv, lr, be_e, lv2, be2);
    vectors++; if (lr !== 32'h00009234) begin miscompares++; $display("FAIL lhu_result: got %h expected 00009234", lr); end
    vectors++; if (be !== 4'b0011) begin miscompares++; $display("FAIL lhu_be: got %b expected 0011", be); end
  endtask

  task automatic test_sub_word_stores();
    int st, rq; logic [31:0] a, w, lr; logic [3:0] be; logic we, mis, lv, be_e, lv2, be2;
    run_op(SH, 32'h202, 32'h1234ABCD, 32'h0, 0, st, rq, a, w, be, we, mis, lv, lr, be_e, lv2, be2);
    vectors++; if (a !== 32'h200) begin miscompares++; $display("FAIL sh_addr: got %h expected 00000200", a); end
    vectors++; if (be !== 4'b1100) begin miscompares++; $display("FAIL sh_be: got %b expected 1100", be); end
    vectors++; if (w !== 32'hABCDABCD) begin miscompares++; $display("FAIL sh_wdata: got %h expected abcdabcd", w); end
    vectors++; if (lv !== 1'b0) begin miscompares++; $display("FAIL sh_loadvalid: got %b expected 0", lv); end
    run_op(SB, 32'h301, 32'h000000A5, 32'h0, 2, st, rq, a, w, be, we, mis, lv, lr, be_e, lv2, be2);
    vectors++; if (be !== 4'b0010) begin miscompares++; $display("FAIL sb_be: got %b expected 0010", be); end
    vectors++; if (w !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL sb_wdata: got %h expected a5a5a5a5", w); end
    vectors++; if (st !== 3) begin miscompares++; $display("FAIL sb_stall_cycles: got %0d expected 3", st); end
  endtask

  task automatic test_mem_none();
    MemOpValid = 1'b1; MemOp = MEM_NONE; ALUResult = 32'h400;
    #1;
    vectors++; if (StallM !== 1'b0) begin miscompares++; $display("FAIL none_stall: got %b expected 0", StallM); end
    @(posedge clk); #1;
    MemOpValid = 1'b0;
    vectors++; if (MemReq !== 1'b0) begin miscompares++; $display("FAIL none_req: got %b expected 0", MemReq); end
    $display("txn op=MEM_NONE ignored");
  endtask

  task automatic test_timeout();
    int st, rq; logic [31:0] a, w, lr; logic [3:0] be; logic we, mis, lv, be_e, lv2, be2;
    run_op(LW, 32'h40, 32'h0, 32'h0, 100, st, rq, a, w, be, we, mis, lv, lr, be_e, lv2, be2);
    vectors++; if (rq !== 4) begin miscompares++; $display("FAIL to_req_cycles: got %0d expected 4", rq); end
    vectors++; if (st !== 4) begin miscompares++; $display("FAIL to_stall_cycles: got %0d expected 4", st); end
    vectors++; if (be_e !== 1'b1) begin miscompares++; $display("FAIL to_buserror: got %b expected 1", be_e); end
    vectors++; if (be2 !== 1'b0) begin miscompares++; $display("FAIL to_buserror_pulse: got %b expected 0", be2); end
    vectors++; if (lv !== 1'b0) begin miscompares++; $display("FAIL to_loadvalid: got %b expected 0", lv); end
    run_op(LW, 32'h44, 32'h0, 32'h12345678, 1, st, rq, a, w, be, we, mis, lv, lr, be_e, lv2, be2);
    vectors++; if (lv !== 1'b1) begin miscompares++; $display("FAIL after_to_loadvalid: got %b expected 1", lv); end
    vectors++; if (lr !== 32'h12345678) begin miscompares++; $display("FAIL after_to_result: got %h expected 12345678", lr); end
    vectors++; if (be_e !== 1'b0) begin miscompares++; $display("FAIL after_to_buserror: got %b expected 0", be_e); end
  endtask

  task automatic test_misalign();
    int st, rq; logic [31:0] a, w, lr; logic [3:0] be; logic we, mis, lv, be_e, lv2, be2;
    run_op(LW, 32'h101, 32'h0, 32'hCAFEF00D, 0, st, rq, a, w, be, we, mis, lv, lr, be_e, lv2, be2);
`ifdef MISALIGN_TRAP_EN
    vectors++; if (rq !== 0) begin miscompares++; $display("FAIL mis_req_cycles: got %0d expected 0", rq); end
    vectors++; if (st !== 0) begin miscompares++; $display("FAIL mis_stall_cycles: got %0d expected 0", st); end
    vectors++; if (mis !== 1'b1) begin miscompares++; $display("FAIL mis_fault: got %b expected 1", mis); end
    vectors++; if (lv !== 1'b0) begin miscompares++; $display("FAIL mis_loadvalid: got %b expected 0", lv); end
`else
    vectors++; if (a !== 32'h100) begin miscompares++; $display("FAIL mis_addr: got %h expected 00000100", a); end
    vectors++; if (be !== 4'b1111) begin miscompares++; $display("FAIL mis_be: got %b expected 1111", be); end
    vectors++; if (lr !== 32'hCAFEF00D) begin miscompares++; $display("FAIL mis_result: got %h expected cafef00d", lr); end
    vectors++; if (mis !== 1'b0) begin miscompares++; $display("FAIL mis_fault: got %b expected 0", mis); end
`endif
  endtask

  task automatic test_reset_mid_transfer();
    int st, rq; logic [31:0] a, w, lr; logic [3:0] be; logic we, mis, lv, be_e, lv2, be2;
    MemOpValid = 1'b1; MemOp = SW; ALUResult = 32'h80; StoreData = 32'h55AA55AA; MemReady = 1'b0;
    @(posedge clk); #1;
    MemOpValid = 1'b0; MemOp = MEM_NONE;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    vectors++; if (StallM !== 1'b0) begin miscompares++; $display("FAIL rst_mid_stall_comb: got %b expected 0", StallM); end
    @(posedge clk); #1;
    vectors++; if (MemReq !== 1'b0) begin miscompares++; $display("FAIL rst_mid_req: got %b expected 0", MemReq); end
    vectors++; if (StallM !== 1'b0) begin miscompares++; $display("FAIL rst_mid_stall: got %b expected 0", StallM); end
    vectors++; if ({LoadResult, MemAddr, MemWData} !== 96'h0) begin
      miscompares++; $display("FAIL rst_mid_data: got %h expected 0", {LoadResult, MemAddr, MemWData}); end
    vectors++; if ({LoadValid, BusError, MemWe, MemByteEn} !== 7'h00) begin
      miscompares++; $display("FAIL rst_mid_flags: got %b expected 0000000", {LoadValid, BusError, MemWe, MemByteEn}); end
    reset = 1'b0;
    @(posedge clk); #1;
    vectors++; if ({LoadValid, BusError, MemReq} !== 3'b000) begin
      miscompares++; $display("FAIL rst_mid_after: got %b expected 000", {LoadValid, BusError, MemReq}); end
    $display("txn reset asserted mid-transfer");
    run_op(LHU, 32'h102, 32'h0, 32'hBEEF1234, 1, st, rq, a, w, be, we, mis, lv, lr, be_e, lv2, be2);
    vectors++; if (lr !== 32'h0000BEEF) begin miscompares++; $display("FAIL rst_next_result: got %h expected 0000beef", lr); end
    vectors++; if (lv !== 1'b1) begin miscompares++; $display("FAIL rst_next_loadvalid: got %b expected 1", lv); end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_loads();
    test_sub_word_stores();
    test_mem_none();
    test_timeout();
    test_misalign();
    test_reset_mid_transfer();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
